// File: rtl/haar_feature_eval_if.sv
// Request/result and integral-memory read bus for haar_feature_eval.
// feat_type carries the feature type code (the word "type" is reserved in SystemVerilog).
interface haar_feature_eval_if #(
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 20,
    parameter int SCORE_W = 23
);
    logic                      start;
    logic [3:0]                feat_type;
    logic [COORD_W-1:0]        x;
    logic [COORD_W-1:0]        y;
    logic [COORD_W-1:0]        w;
    logic [COORD_W-1:0]        h;
    logic signed [SCORE_W-1:0] threshold;
    logic                      polarity;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic signed [SCORE_W-1:0] score;
    logic                      vote;
    logic                      mem_rd_en;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_rd_data;

    modport master (
        output start, feat_type, x, y, w, h, threshold, polarity, mem_rd_data,
        input  busy, done, err, score, vote, mem_rd_en, mem_addr
    );

    modport slave (
        input  start, feat_type, x, y, w, h, threshold, polarity, mem_rd_data,
        output busy, done, err, score, vote, mem_rd_en, mem_addr
    );
endinterface

// File: rtl/haar_feature_eval.sv
// Sequential Haar-like feature evaluator reading corners from a zero-padded integral image.
// Define HAAR_FEAT_TYPE4_EN to enable the 4-rect checkerboard (type 4); otherwise type 4 is rejected.
//
// state    | meaning
// S_IDLE   | waiting for start, outputs held
// S_CHECK  | validate latched descriptor
// S_READ   | issue one corner read per cycle
// S_DRAIN  | wait for the last read return
// S_DECIDE | register score and vote
// S_DONE   | pulse done, release busy
module haar_feature_eval #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 20,
    parameter int SCORE_W = 23,
    parameter int RD_LAT  = 1
) (
    input logic                clk,
    input logic                rst,
    haar_feature_eval_if.slave bus
);
    localparam int EW = COORD_W + 3;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN, S_DECIDE, S_DONE} state_t;

    state_t                    state;
    logic [3:0]                ftype_q;
    logic [COORD_W-1:0]        x_q, y_q, w_q, h_q;
    logic signed [SCORE_W-1:0] thr_q;
    logic                      pol_q;
    logic [4:0]                rd_idx;
    logic [4:0]                ret_cnt;
    logic signed [SCORE_W-1:0] acc;
    logic                      rd_en_q, rd_neg_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [RD_LAT-1:0]         vld_p, neg_p;
    logic                      busy_q, done_q, err_q, vote_q;
    logic signed [SCORE_W-1:0] score_q;

    logic                      type_ok, reject, w_neg, rd_neg;
    logic [1:0]                kx, ky, rect;
    logic [4:0]                n_rd;
    logic [EW-1:0]             xe, ye, we, he, x_end, y_end, cx, cy;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [SCORE_W-1:0] ext;

    assign xe    = EW'(x_q);
    assign ye    = EW'(y_q);
    assign we    = EW'(w_q);
    assign he    = EW'(h_q);
    assign rect  = rd_idx[3:2];
    assign ext   = {{(SCORE_W-DATA_W){1'b0}}, bus.mem_rd_data};
    assign x_end = xe + EW'(kx) * we;
    assign y_end = ye + EW'(ky) * he;
    assign reject = !type_ok || (w_q == '0) || (h_q == '0) ||
                    (x_end > EW'(IMG_W)) || (y_end > EW'(IMG_H));

    always_comb begin
        type_ok = 1'b0;
        kx      = 2'd1;
        ky      = 2'd1;
        n_rd    = 5'd8;
        case (ftype_q)
            4'd0: begin type_ok = 1'b1; kx = 2'd2; end
            4'd1: begin type_ok = 1'b1; ky = 2'd2; end
            4'd2: begin type_ok = 1'b1; kx = 2'd3; n_rd = 5'd12; end
            4'd3: begin type_ok = 1'b1; ky = 2'd3; n_rd = 5'd12; end
`ifdef HAAR_FEAT_TYPE4_EN
            4'd4: begin type_ok = 1'b1; kx = 2'd2; ky = 2'd2; n_rd = 5'd16; end
`endif
            default: ;
        endcase
    end

    // rd_idx[3:2] selects the sub-rectangle, rd_idx[1:0] the corner (bit0 adds w, bit1 adds h)
    always_comb begin
        cx    = xe;
        cy    = ye;
        w_neg = 1'b0;
        case (ftype_q)
            4'd0, 4'd2: begin cx = xe + EW'(rect) * we; w_neg = (rect == 2'd1); end
            4'd1, 4'd3: begin cy = ye + EW'(rect) * he; w_neg = (rect == 2'd1); end
`ifdef HAAR_FEAT_TYPE4_EN
            4'd4: begin
                cx    = rect[0] ? xe + we : xe;
                cy    = rect[1] ? ye + he : ye;
                w_neg = rect[0] ^ rect[1];
            end
`endif
            default: ;
        endcase
        if (rd_idx[0]) cx = cx + we;
        if (rd_idx[1]) cy = cy + he;
        rd_neg  = w_neg ^ rd_idx[0] ^ rd_idx[1];
        rd_addr = ADDR_W'(cy) * ADDR_W'(IMG_W + 1) + ADDR_W'(cx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ftype_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            thr_q    <= '0;
            pol_q    <= 1'b0;
            rd_idx   <= '0;
            ret_cnt  <= '0;
            acc      <= '0;
            rd_en_q  <= 1'b0;
            rd_neg_q <= 1'b0;
            addr_q   <= '0;
            vld_p    <= '0;
            neg_p    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vote_q   <= 1'b0;
            score_q  <= '0;
        end else begin
            vld_p[0] <= rd_en_q;
            neg_p[0] <= rd_neg_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                neg_p[i] <= neg_p[i-1];
            end
            if (vld_p[RD_LAT-1]) begin
                acc     <= neg_p[RD_LAT-1] ? acc - ext : acc + ext;
                ret_cnt <= ret_cnt + 5'd1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ftype_q <= bus.feat_type;
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        w_q     <= bus.w;
                        h_q     <= bus.h;
                        thr_q   <= bus.threshold;
                        pol_q   <= bus.polarity;
                        rd_idx  <= '0;
                        ret_cnt <= '0;
                        acc     <= '0;
                        err_q   <= 1'b0;
                        score_q <= '0;
                        vote_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (reject) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        rd_en_q  <= 1'b1;
                        addr_q   <= rd_addr;
                        rd_neg_q <= rd_neg;
                        rd_idx   <= rd_idx + 5'd1;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_idx == n_rd) begin
                        rd_en_q <= 1'b0;
                        state   <= S_DRAIN;
                    end else begin
                        addr_q   <= rd_addr;
                        rd_neg_q <= rd_neg;
                        rd_idx   <= rd_idx + 5'd1;
                    end
                end
                S_DRAIN: begin
                    if (vld_p[RD_LAT-1] && (ret_cnt == n_rd - 5'd1)) state <= S_DECIDE;
                end
                S_DECIDE: begin
                    score_q <= acc;
                    vote_q  <= pol_q ? (acc < thr_q) : (acc >= thr_q);
                    done_q  <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.score     = score_q;
    assign bus.vote      = vote_q;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
endmodule

// File: tb/tb_haar_feature_eval.sv
// Directed bench for haar_feature_eval with a behavioural integral-image memory (RD_LAT = 1).
module tb_haar_feature_eval;
    localparam int IMG_W = 160, IMG_H = 120, COORD_W = 8, ADDR_W = 15;
    localparam int DATA_W = 20, SCORE_W = 23, RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   img_mode = 0;

    haar_feature_eval_if #(.COORD_W(COORD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCORE_W(SCORE_W)) bus ();

    haar_feature_eval #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .SCORE_W(SCORE_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ii(input int r, input int c);
        if (img_mode == 0) return r * c * (c - 1) / 2;
        return r * c;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rd_data <= DATA_W'(ii(int'(bus.mem_addr) / (IMG_W + 1), int'(bus.mem_addr) % (IMG_W + 1)));
    end

    int rd_cnt, rd_first, rd_last;
    int addr_log[$];
    always @(negedge clk) begin
        if (bus.mem_rd_en) begin
            if (rd_cnt == 0) rd_first = cyc;
            rd_last = cyc;
            rd_cnt++;
            addr_log.push_back(int'(bus.mem_addr));
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    int  t0, done_cyc;
    bit  done_seen;

    task automatic req(input logic [3:0] t, input int xi, input int yi, input int wi, input int hi,
                       input int thr, input logic pol, input int mid_start);
        @(negedge clk);
        bus.feat_type = t;
        bus.x = COORD_W'(xi);
        bus.y = COORD_W'(yi);
        bus.w = COORD_W'(wi);
        bus.h = COORD_W'(hi);
        bus.threshold = SCORE_W'(thr);
        bus.polarity = pol;
        bus.start = 1'b1;
        t0 = cyc;
        rd_cnt = 0;
        addr_log.delete();
        done_seen = 0;
        done_cyc = 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.feat_type = 4'hF;
        bus.x = '0;
        bus.w = '0;
        for (int k = 0; k < 60; k++) begin
            if (bus.done) begin
                done_seen = 1;
                done_cyc = cyc;
                break;
            end
            bus.start = (mid_start != 0 && cyc == t0 + mid_start);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!done_seen) check("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int lat, input int sc, input logic vt, input logic er);
        check({tag, "_done_lat"}, done_cyc - t0, lat);
        check({tag, "_score"}, $signed(bus.score), sc);
        check({tag, "_vote"}, bus.vote, vt);
        check({tag, "_err"}, bus.err, er);
        check({tag, "_busy"}, bus.busy, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_score"}, $signed(bus.score), 0);
        check({tag, "_vote"}, bus.vote, 0);
        check({tag, "_rd_en"}, bus.mem_rd_en, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
    endtask

    initial begin
        int exp_a[8];
        int dn;
        bus.start = 1'b0;
        bus.feat_type = '0;
        bus.x = '0; bus.y = '0; bus.w = '0; bus.h = '0;
        bus.threshold = '0;
        bus.polarity = 1'b0;
        bus.mem_rd_data = '0;
        rd_cnt = 0;

        #2 rst = 1'b1;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // column-index image: L sums cols 0..1 = 1, R sums cols 2..3 = 5
        img_mode = 0;
        req(4'd0, 0, 0, 2, 1, -4, 1'b0, 0);
        check_result("t0", 12, -4, 1'b1, 1'b0);
        check("t0_rd_cnt", rd_cnt, 8);
        check("t0_rd_first", rd_first - t0, 2);
        check("t0_rd_last", rd_last - t0, 9);
        exp_a = '{0, 2, 161, 163, 2, 4, 163, 165};
        for (int i = 0; i < 8; i++) check("t0_addr", (i < addr_log.size()) ? addr_log[i] : -1, exp_a[i]);

        img_mode = 1;
        req(4'd2, 3, 2, 4, 5, 1, 1'b0, 0);
        check_result("pol0", 16, 20, 1'b1, 1'b0);
        check("pol0_rd_cnt", rd_cnt, 12);
        req(4'd2, 3, 2, 4, 5, 1, 1'b1, 0);
        check_result("pol1", 16, 20, 1'b0, 1'b0);

        req(4'd2, 150, 0, 4, 1, 0, 1'b0, 0);
        check_result("oob", 2, 0, 1'b0, 1'b1);
        check("oob_rd_cnt", rd_cnt, 0);
        req(4'd0, 0, 0, 0, 1, -5, 1'b0, 0);
        check_result("w0", 2, 0, 1'b0, 1'b1);
        check("w0_rd_cnt", rd_cnt, 0);
        req(4'd7, 0, 0, 1, 1, -5, 1'b0, 0);
        check_result("badtype", 2, 0, 1'b0, 1'b1);

        // top 2x2 and bottom 2x2 are equal -> 0; stray start at T0+5 must be ignored
        req(4'd1, 0, 0, 2, 2, 0, 1'b0, 5);
        check_result("busy", 12, 0, 1'b1, 1'b0);
        dn = done_cyc;
        req(4'd0, 0, 0, 3, 2, 0, 1'b1, 0);
        check("b2b_t0", t0, dn + 1);
        check_result("b2b", 12, 0, 1'b0, 1'b0);

        // reset in the middle of READ
        img_mode = 0;
        @(negedge clk);
        bus.feat_type = 4'd0; bus.x = '0; bus.y = '0; bus.w = 8'd2; bus.h = 8'd1;
        bus.threshold = '0; bus.polarity = 1'b0; bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        check("rst_mid_rd_en_before", bus.mem_rd_en, 1);
        rst = 1'b1;
        #1 check_idle_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("rst_mid_no_done", dn, 0);
        req(4'd0, 0, 0, 2, 1, -3, 1'b0, 0);
        check_result("post_rst", 12, -4, 1'b0, 1'b0);

        img_mode = 1;
        req(4'd4, 0, 0, 2, 2, 0, 1'b0, 0);
`ifdef HAAR_FEAT_TYPE4_EN
        check_result("type4", 20, 0, 1'b1, 1'b0);
        check("type4_rd_cnt", rd_cnt, 16);
`else
        check_result("type4", 2, 0, 1'b0, 1'b1);
        check("type4_rd_cnt", rd_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
